// File: rtl/alu_cmd_ctrl_if.sv
// alu_cmd_ctrl_if: groups the RX byte stream, the ALU operation port and the
// TX byte handshake seen by alu_cmd_ctrl.
//   master : the command controller (drives ALU inputs and TX bytes)
//   slave  : the surrounding system (UART RX/TX and the ALU)
interface alu_cmd_ctrl_if;
   // receive byte stream
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   // ALU operation port
   logic        ALU_EN;
   logic [7:0]  ALU_A;
   logic [7:0]  ALU_B;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   // transmit byte handshake
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   // status
   logic        BUSY;
   logic        ERR;

   modport master (
      input  RX_DATA, RX_VALID, ALU_OUT, OUT_VALID, TX_READY,
      output ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_DATA, TX_VALID, BUSY, ERR
   );

   modport slave (
      output RX_DATA, RX_VALID, ALU_OUT, OUT_VALID, TX_READY,
      input  ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_DATA, TX_VALID, BUSY, ERR
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: collects a {hdr|fun, A, B} command frame from the RX byte
// stream, fires one ALU operation, waits (bounded by TIMEOUT) for the result
// and returns it low byte first over the TX valid/ready handshake.
// Optional feature macro: ALU_CTRL_ECHO_EN -- when defined, the received
// command byte is transmitted ahead of the two result bytes.
// Every output is a flop; the output registers are loaded from the
// next-state decode so ALU_EN / TX_VALID / BUSY line up with the state.
module alu_cmd_ctrl #(
   parameter int         TIMEOUT = 15,
   parameter logic [3:0] CMD_HDR = 4'hA
) (
   input  logic          CLK,
   input  logic          RST,
   alu_cmd_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_ISSUE,
      S_WAIT,
`ifdef ALU_CTRL_ECHO_EN
      S_SEND_CMD,
`endif
      S_SEND_LO,
      S_SEND_HI
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;

   // frame / result holding registers
   logic [7:0]  cmd_q;
   logic [7:0]  alu_a_q;
   logic [7:0]  alu_b_q;
   logic [3:0]  alu_fun_q;
   logic [15:0] result_q;
   logic [7:0]  cnt_q;

   // registered outputs
   logic        alu_en_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        busy_q;
   logic        err_q;

   // combinational decode
   logic        lat_cmd, lat_a, lat_b, cap_res, cnt_clr, cnt_inc;
   logic        err_nxt;
   logic [15:0] result_nxt;
   logic [7:0]  tx_data_nxt;
   logic        tx_valid_nxt;
   logic        busy_nxt;
   logic        alu_en_nxt;
   state_t      first_send;

`ifdef ALU_CTRL_ECHO_EN
   assign first_send = S_SEND_CMD;
`else
   assign first_send = S_SEND_LO;
`endif

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state decode, latch strobes and next values of the output flops
   always_comb begin
      state_nxt    = state;
      lat_cmd      = 1'b0;
      lat_a        = 1'b0;
      lat_b        = 1'b0;
      cap_res      = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      err_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.RX_VALID) begin
               if (bus.RX_DATA[7:4] == CMD_HDR) begin
                  lat_cmd   = 1'b1;
                  state_nxt = S_GET_A;
               end else begin
                  // bad header: byte is discarded, flag it
                  err_nxt = 1'b1;
               end
            end
         end
         S_GET_A: begin
            if (bus.RX_VALID) begin
               lat_a     = 1'b1;
               state_nxt = S_GET_B;
            end
         end
         S_GET_B: begin
            if (bus.RX_VALID) begin
               lat_b     = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_clr   = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // a result arriving in the last allowed cycle still wins
            if (bus.OUT_VALID) begin
               cap_res   = 1'b1;
               state_nxt = first_send;
            end else if (cnt_q == CNT_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
`ifdef ALU_CTRL_ECHO_EN
         S_SEND_CMD: begin
            if (bus.TX_READY) state_nxt = S_SEND_LO;
         end
`endif
         S_SEND_LO: begin
            if (bus.TX_READY) state_nxt = S_SEND_HI;
         end
         S_SEND_HI: begin
            if (bus.TX_READY) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // the low byte must be loadable in the same edge the result is captured
      result_nxt = cap_res ? bus.ALU_OUT : result_q;

      tx_valid_nxt = 1'b0;
      tx_data_nxt  = 8'h00;
      case (state_nxt)
`ifdef ALU_CTRL_ECHO_EN
         S_SEND_CMD: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = cmd_q;
         end
`endif
         S_SEND_LO: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = result_nxt[7:0];
         end
         S_SEND_HI: begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = result_nxt[15:8];
         end
         default: begin
            tx_valid_nxt = 1'b0;
            tx_data_nxt  = 8'h00;
         end
      endcase

      alu_en_nxt = (state_nxt == S_ISSUE);
      busy_nxt   = !(state_nxt == S_IDLE || state_nxt == S_GET_A ||
                     state_nxt == S_GET_B);
   end

   // frame capture, operand/function hold and result register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cmd_q     <= 8'h00;
         alu_a_q   <= 8'h00;
         alu_b_q   <= 8'h00;
         alu_fun_q <= 4'h0;
         result_q  <= 16'h0000;
      end else begin
         if (lat_cmd) begin
            cmd_q     <= bus.RX_DATA;
            alu_fun_q <= bus.RX_DATA[3:0];
         end
         if (lat_a) alu_a_q <= bus.RX_DATA;
         if (lat_b) alu_b_q <= bus.RX_DATA;
         result_q <= result_nxt;
      end
   end

   // WAIT-state timeout counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          cnt_q <= 8'h00;
      else if (cnt_clr) cnt_q <= 8'h00;
      else if (cnt_inc) cnt_q <= cnt_q + 8'h01;
   end

   // output flops loaded from the next-state decode
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         alu_en_q   <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         alu_en_q   <= alu_en_nxt;
         tx_data_q  <= tx_data_nxt;
         tx_valid_q <= tx_valid_nxt;
         busy_q     <= busy_nxt;
         err_q      <= err_nxt;
      end
   end

   assign bus.ALU_EN   = alu_en_q;
   assign bus.ALU_A    = alu_a_q;
   assign bus.ALU_B    = alu_b_q;
   assign bus.ALU_FUN  = alu_fun_q;
   assign bus.TX_DATA  = tx_data_q;
   assign bus.TX_VALID = tx_valid_q;
   assign bus.BUSY     = busy_q;
   assign bus.ERR      = err_q;

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side front end for the system ALU. Collects a 3-byte command frame (command, operand A, operand B) from the receive byte stream, issues one ALU operation via the ALU's EN/A/B/ALU_FUN inputs, waits for OUT_VALID, and returns the 16-bit ALU_OUT as bytes to the transmit path over a valid/ready handshake. Sits between the UART RX/TX byte interfaces and the ALU in the main clock domain.

## Interface
- TIMEOUT, 15: cycles to wait in WAIT for OUT_VALID before aborting (legal 2..255).
- CMD_HDR, 4'hA: required upper nibble of the command byte.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid.
- ALU_EN  out  1  one-cycle operation strobe to ALU EN.
- ALU_A  out  8  operand A to ALU.
- ALU_B  out  8  operand B to ALU.
- ALU_FUN  out  4  function code to ALU.
- ALU_OUT  in  16  ALU result.
- OUT_VALID  in  1  ALU result valid.
- TX_DATA  out  8  byte to transmitter.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  transmitter accepts byte.
- BUSY  out  1  high in ISSUE, WAIT and all SEND states.
- ERR  out  1  one-cycle pulse on header error or timeout.

## Operation
- Frame: byte0 = {CMD_HDR, FUN}; byte1 = A; byte2 = B.
- States: IDLE, GET_A, GET_B, ISSUE, WAIT, SEND_LO, SEND_HI (plus SEND_CMD when echo is compiled in).
- IDLE: RX_VALID with RX_DATA[7:4]==CMD_HDR -> latch FUN, go GET_A; header mismatch -> ERR pulse, byte dropped, stay IDLE.
- GET_A: RX_VALID -> latch A, go GET_B. GET_B: RX_VALID -> latch B, go ISSUE.
- ISSUE: ALU_EN=1 for exactly one cycle; go WAIT, clear timeout counter.
- WAIT: OUT_VALID -> capture ALU_OUT into result register, go first SEND state. Counter increments each WAIT cycle; reaching TIMEOUT without OUT_VALID -> ERR pulse, go IDLE, no TX. OUT_VALID in the final timeout cycle wins (result taken, no ERR).
- SEND_LO drives result[7:0], SEND_HI drives result[15:8]; each holds TX_VALID=1 and TX_DATA stable until the edge where TX_READY=1, then advances. After SEND_HI accept -> IDLE.
- ALU_A/ALU_B/ALU_FUN are registered, updated only at latch, held stable until the next frame overwrites them.
- RX_VALID while BUSY: byte dropped, no ERR. OUT_VALID outside WAIT: ignored.
- FUN is not range-checked; unsupported codes (e.g. 4'hF) produce no OUT_VALID and end in timeout.

## Timing
- Reset (async, immediate): state IDLE; ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_DATA, TX_VALID, BUSY, ERR all 0; counter and result cleared. Reset mid-frame discards partial frame and any pending TX byte.
- Byte B accepted at edge E -> ALU_EN high in cycle E+1.
- Registered ALU: OUT_VALID high in cycle E+2; result captured at end of E+2; TX_VALID first high in E+3.
- Minimum frame-to-last-byte-accepted: 2 cycles after TX_VALID rises with TX_READY tied high (3 with echo).
- ERR is exactly one cycle wide; timeout ERR asserts in the cycle after the TIMEOUT-th WAIT cycle.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- ALU_CTRL_ECHO_EN defined: a SEND_CMD state precedes SEND_LO and transmits the received command byte, so each response is {cmd, result[7:0], result[15:8]}.
- Undefined: response is {result[7:0], result[15:8]} only; SEND_CMD does not exist.

## Test plan
- Frame A0,05,03 with ALU model, TX_READY=1 -> ALU_EN one cycle with A=05 B=03 FUN=0; TX bytes 08 then 00; BUSY low after.
- Frame A2,FF,FF, TX_READY low 5 cycles after TX_VALID rises -> TX_DATA held 01 throughout, then 01, FE sent.
- Byte 50 in IDLE -> single-cycle ERR, no ALU_EN; following frame A0,01,01 returns 02,00.
- Frame AF,10,20 (ALU never asserts OUT_VALID) -> ERR exactly TIMEOUT+1 cycles after ALU_EN, no TX_VALID, state IDLE; RX bytes sent during WAIT are dropped.
- RST pulsed after byte A of a frame -> all outputs 0 immediately; fresh frame A1,09,04 returns 05,00.
- With ALU_CTRL_ECHO_EN: frame A0,05,03 -> TX bytes A0, 08, 00.
